// File: rtl/microwave_pkg.sv
// microwave_pkg
// Shared types and constants for the microwave countdown timer.
//   state_e    : controller states, with fixed encodings because the display
//                and debug logic read them directly from state_o
//   alu_op_e   : operation select for bcd_time_alu
//   bcd_time_t : the four BCD digits of an mm:ss time, most significant first
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_DEC1  = 2'd1,
        OP_ADD30 = 2'd2,
        OP_NORM  = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [3:0] min_t;   // minutes tens
        logic [3:0] min_u;   // minutes units
        logic [3:0] sec_t;   // seconds tens
        logic [3:0] sec_u;   // seconds units
    } bcd_time_t;

    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_time_alu.sv
// bcd_time_alu
// Combinational BCD arithmetic on an mm:ss time.
//   op_i   : OP_PASS  - time returned unchanged
//            OP_DEC1  - subtract one second with BCD borrow (00:00 stays 00:00)
//            OP_ADD30 - add QUICK_SEC_T tens of seconds, carrying into minutes
//            OP_NORM  - fold a seconds-tens digit above 5 into the minutes
//   time_i : input time digits
//   time_o : result digits; minute overflow saturates at MAX_MIN_T9:59
//   zero_o : result is 00:00
module bcd_time_alu
    import microwave_pkg::*;
#(
    parameter logic [3:0] QUICK_SEC_T = 4'd3,
    parameter logic [3:0] MAX_MIN_T   = 4'd9
) (
    input  alu_op_e   op_i,
    input  bcd_time_t time_i,
    output bcd_time_t time_o,
    output logic      zero_o
);

    bcd_time_t  res;
    logic       carry_min;
    logic [4:0] sec_sum;
    logic [4:0] sec_adj;

    always_comb begin
        res       = time_i;
        carry_min = 1'b0;
        sec_sum   = {1'b0, time_i.sec_t} + {1'b0, QUICK_SEC_T};
        sec_adj   = sec_sum - 5'd6;

        case (op_i)
            OP_DEC1: begin
                if (time_i != '0) begin
                    if (time_i.sec_u != 4'd0) begin
                        res.sec_u = time_i.sec_u - 4'd1;
                    end else begin
                        res.sec_u = DIGIT_MAX;
                        if (time_i.sec_t != 4'd0) begin
                            res.sec_t = time_i.sec_t - 4'd1;
                        end else begin
                            res.sec_t = SEC_T_MAX;
                            if (time_i.min_u != 4'd0) begin
                                res.min_u = time_i.min_u - 4'd1;
                            end else begin
                                res.min_u = DIGIT_MAX;
                                res.min_t = time_i.min_t - 4'd1;
                            end
                        end
                    end
                end
            end
            OP_ADD30: begin
                if (sec_sum > {1'b0, SEC_T_MAX}) begin
                    res.sec_t = sec_adj[3:0];
                    carry_min = 1'b1;
                end else begin
                    res.sec_t = sec_sum[3:0];
                end
            end
            OP_NORM: begin
                // Keypad entry allows 60..99 in the seconds field.
                if (time_i.sec_t > SEC_T_MAX) begin
                    res.sec_t = time_i.sec_t - 4'd6;
                    carry_min = 1'b1;
                end
            end
            default: ;
        endcase

        // One-minute carry shared by add and normalize.
        if (carry_min) begin
            if (time_i.min_u < DIGIT_MAX) begin
                res.min_u = time_i.min_u + 4'd1;
            end else if (time_i.min_t < MAX_MIN_T) begin
                res.min_u = 4'd0;
                res.min_t = time_i.min_t + 4'd1;
            end else begin
                res.min_t = MAX_MIN_T;
                res.min_u = DIGIT_MAX;
                res.sec_t = SEC_T_MAX;
                res.sec_u = DIGIT_MAX;
            end
        end
    end

    assign time_o = res;
    assign zero_o = (res == '0);

endmodule

// File: rtl/microwave_countdown.sv
// microwave_countdown
// Keypad-entered mm:ss countdown controller driving the magnetron enable.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sec_tick            : one-cycle pulse per second
//   key_valid/key_digit : keypad entry, digits above 9 ignored
//   start, stop         : one-cycle command pulses
//   door_open           : door sensor level
//   first_s..second_m   : registered BCD time digits (ss units .. mm tens)
//   magnetron_on        : registered, high exactly while in RUN
//   state_o             : current state encoding
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter logic [3:0] QUICK_SEC_T = 4'd3,
    parameter logic [3:0] MAX_MIN_T   = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] first_s,
    output logic [3:0] second_s,
    output logic [3:0] first_m,
    output logic [3:0] second_m,
    output logic       magnetron_on,
    output logic [2:0] state_o
);

    state_e    state_q, state_d;
    bcd_time_t time_q, time_d;
    logic      mag_q, mag_d;

    alu_op_e   alu_op;
    bcd_time_t alu_time;
    logic      alu_zero;
    bcd_time_t shifted;
    logic      key_ok;
    logic      start_ok;

    assign key_ok   = key_valid && (key_digit <= DIGIT_MAX);
    assign start_ok = start && !door_open;
    // Keypad entry scrolls in from the right; the old minutes-tens digit drops off.
    assign shifted  = '{min_t: time_q.min_u, min_u: time_q.sec_t,
                        sec_t: time_q.sec_u, sec_u: key_digit};

    // Operation select depends only on registered state and inputs, so the
    // ALU result can feed the next-state logic without a combinational loop.
    always_comb begin
        alu_op = OP_PASS;
        case (state_q)
            SET:     alu_op = OP_NORM;
            RUN:     alu_op = start ? OP_ADD30 : OP_DEC1;
            default: alu_op = OP_PASS;
        endcase
    end

    bcd_time_alu #(
        .QUICK_SEC_T (QUICK_SEC_T),
        .MAX_MIN_T   (MAX_MIN_T)
    ) u_alu (
        .op_i   (alu_op),
        .time_i (time_q),
        .time_o (alu_time),
        .zero_o (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;

        case (state_q)
            IDLE: begin
                if (stop) begin
                    time_d = '0;
                end else if (start_ok) begin
                    time_d  = '{min_t: 4'd0, min_u: 4'd0, sec_t: QUICK_SEC_T, sec_u: 4'd0};
                    state_d = RUN;
                end else if (key_ok) begin
                    time_d  = shifted;
                    state_d = SET;
                end
            end
            SET: begin
                if (stop) begin
                    time_d  = '0;
                    state_d = IDLE;
                end else if (start_ok) begin
                    if (alu_zero) begin
                        time_d  = '0;
                        state_d = IDLE;
                    end else begin
                        time_d  = alu_time;
                        state_d = RUN;
                    end
                end else if (key_ok) begin
                    time_d = shifted;
                end
            end
            RUN: begin
                // Door opening pauses before any start or tick is honoured.
                if (stop || door_open) begin
                    state_d = PAUSE;
                end else if (start) begin
                    time_d = alu_time;
                end else if (sec_tick) begin
                    time_d = alu_time;
                    if (alu_zero) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    time_d  = '0;
                    state_d = IDLE;
                end else if (start_ok) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (stop || start || key_valid) begin
                    time_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                time_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign mag_d = (state_d == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            mag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            mag_q   <= mag_d;
        end
    end

    assign first_s      = time_q.sec_u;
    assign second_s     = time_q.sec_t;
    assign first_m      = time_q.min_u;
    assign second_m     = time_q.min_t;
    assign magnetron_on = mag_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_microwave_countdown.sv
// tb_microwave_countdown
// Directed scenarios followed by randomized stimulus, all checked against a
// reference model that tracks keypad digits while entering and a plain count
// of seconds once the timer is loaded.
module tb_microwave_countdown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] first_s, second_s, first_m, second_m;
    logic       magnetron_on;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
    localparam int MAX_T = 99 * 60 + 59;

    int m_state = M_IDLE;
    int m_d[4] = '{0, 0, 0, 0};   // [3]=min tens .. [0]=sec units while entering
    int m_t = 0;                   // seconds remaining once loaded

    microwave_countdown dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sec_tick     (sec_tick),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop         (stop),
        .door_open    (door_open),
        .first_s      (first_s),
        .second_s     (second_s),
        .first_m      (first_m),
        .second_m     (second_m),
        .magnetron_on (magnetron_on),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    wire [15:0] dut_time = {second_m, first_m, second_s, first_s};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_time();
        int mins, secs;
        logic [15:0] r;
        if (m_state == M_IDLE || m_state == M_SET) begin
            r = {m_d[3][3:0], m_d[2][3:0], m_d[1][3:0], m_d[0][3:0]};
        end else begin
            mins = m_t / 60;
            secs = m_t % 60;
            r = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
        end
        return r;
    endfunction

    task automatic model_clear();
        m_state = M_IDLE;
        m_t = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    task automatic model_shift(input int d);
        m_d[3] = m_d[2];
        m_d[2] = m_d[1];
        m_d[1] = m_d[0];
        m_d[0] = d;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit kv, input int kd,
                              input bit dr, input bit tk);
        int mins, secs;
        case (m_state)
            M_IDLE: begin
                if (sp) begin
                end else if (st && !dr) begin
                    m_t = 30;
                    m_state = M_RUN;
                end else if (kv && kd <= 9) begin
                    model_shift(kd);
                    m_state = M_SET;
                end
            end
            M_SET: begin
                if (sp) begin
                    model_clear();
                end else if (st && !dr) begin
                    mins = m_d[3] * 10 + m_d[2];
                    secs = m_d[1] * 10 + m_d[0];
                    if (secs >= 60) begin
                        mins++;
                        secs -= 60;
                    end
                    if (mins > 99) begin
                        mins = 99;
                        secs = 59;
                    end
                    if (mins * 60 + secs == 0) begin
                        model_clear();
                    end else begin
                        m_t = mins * 60 + secs;
                        m_state = M_RUN;
                    end
                end else if (kv && kd <= 9) begin
                    model_shift(kd);
                end
            end
            M_RUN: begin
                if (sp || dr) begin
                    m_state = M_PAUSE;
                end else if (st) begin
                    m_t = (m_t + 30 > MAX_T) ? MAX_T : m_t + 30;
                end else if (tk) begin
                    m_t--;
                    if (m_t == 0) m_state = M_DONE;
                end
            end
            M_PAUSE: begin
                if (sp) model_clear();
                else if (st && !dr) m_state = M_RUN;
            end
            default: begin
                if (sp || st || kv) model_clear();
            end
        endcase
    endtask

    // One clock of stimulus: drive at the falling edge, update the model,
    // then compare every output just after the rising edge.
    task automatic step(input bit st, input bit sp, input bit kv, input logic [3:0] kd,
                        input bit dr, input bit tk);
        @(negedge clk);
        start = st; stop = sp; key_valid = kv; key_digit = kd;
        door_open = dr; sec_tick = tk;
        model_step(st, sp, kv, int'(kd), dr, tk);
        @(posedge clk);
        #1;
        check("time", 32'(dut_time), 32'(model_time()));
        check("state", 32'(state_o), 32'(m_state));
        check("magnetron", 32'(magnetron_on), 32'(m_state == M_RUN));
        $display("st=%0d sp=%0d kv=%0d key=%0h door=%0d tick=%0d -> %h:%h state=%0d mag=%0d",
                 st, sp, kv, kd, dr, tk, dut_time[15:8], dut_time[7:0], state_o, magnetron_on);
        start = 1'b0; stop = 1'b0; key_valid = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic key(input int d);
        step(1'b0, 1'b0, 1'b1, 4'(d), 1'b0, 1'b0);
    endtask

    task automatic press_start();
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic press_stop();
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    // Reset pulse placed mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check({tag, "_time"}, 32'(dut_time), 32'h0);
        check({tag, "_state"}, 32'(state_o), 32'(M_IDLE));
        check({tag, "_mag"}, 32'(magnetron_on), 32'h0);
        $display("async reset %s -> %h:%h state=%0d mag=%0d",
                 tag, dut_time[15:8], dut_time[7:0], state_o, magnetron_on);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit st, sp, kv, tk, dr;
        logic [3:0] kd;

        #12;
        check("reset_time", 32'(dut_time), 32'h0);
        check("reset_state", 32'(state_o), 32'(M_IDLE));
        check("reset_mag", 32'(magnetron_on), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 01:30 entry, full countdown to DONE
        key(1); key(3); key(0); press_start();
        check("load_0130", 32'(dut_time), 32'h0130);
        check("load_run", 32'(magnetron_on), 32'h1);
        ticks(89);
        check("at_0001", 32'(dut_time), 32'h0001);
        ticks(1);
        check("done_time", 32'(dut_time), 32'h0000);
        check("done_state", 32'(state_o), 32'(M_DONE));
        check("done_mag", 32'(magnetron_on), 32'h0);
        press_start();
        check("done_exit", 32'(state_o), 32'(M_IDLE));

        // Normalization and saturation of keyed times
        key(9); key(0); press_start();
        check("norm_0130", 32'(dut_time), 32'h0130);
        press_stop(); press_stop();
        key(9); key(9); key(9); key(9); press_start();
        check("sat_9959", 32'(dut_time), 32'h9959);
        press_stop(); press_stop();

        // Quick start and +30 s
        press_start();
        check("quick_0030", 32'(dut_time), 32'h0030);
        ticks(5);
        check("quick_0025", 32'(dut_time), 32'h0025);
        press_start();
        check("add_0055", 32'(dut_time), 32'h0055);
        press_stop(); press_stop();
        key(9); key(9); key(4); key(5); press_start();
        check("load_9945", 32'(dut_time), 32'h9945);
        press_start();
        check("add_sat_9959", 32'(dut_time), 32'h9959);
        press_stop(); press_stop();

        // Door beats tick
        key(2); key(0); key(0); press_start();
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("door_pause", 32'(state_o), 32'(M_PAUSE));
        check("door_hold", 32'(dut_time), 32'h0200);
        press_start();
        ticks(1);
        check("resume_0159", 32'(dut_time), 32'h0159);

        // Stop beats start; out-of-range key ignored
        press_stop();
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("stop_wins", 32'(state_o), 32'(M_IDLE));
        key(10);
        check("key_A_ignored", 32'(state_o), 32'(M_IDLE));

        // Asynchronous reset mid-RUN
        key(4); key(2); press_start();
        check("load_0042", 32'(dut_time), 32'h0042);
        mid_reset("run_reset");

        // Randomized phase
        dr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 59) == 0);
            sp = ($urandom_range(0, 39) == 0);
            kv = ($urandom_range(0, 5) == 0);
            tk = ($urandom_range(0, 9) < 6);
            kd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) dr = ~dr;
            step(st, sp, kv, kd, dr, tk);
            if (i % 500 == 499) mid_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/microwave_countdown.md
Name: microwave_countdown

Overview:
- Upstream timer stage that produces the four BCD time digits consumed by the end-of-cook buzzer/power-off stage.
- Accepts keypad digit entry, plus start, stop and door-open controls.
- Counts the entered mm:ss time down once per one-second tick and drives the magnetron enable.
- Reaching 00:00 in RUN lets the downstream stage detect completion from the all-zero digits.

Parameters:
- QUICK_SEC_T, 4'd3: seconds-tens digit added by quick-start / +30 s (a value of 3 means 30 s).
- MAX_MIN_T, 4'd9: saturation value of the minutes-tens digit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse, once per second, synchronous to clk
- key_valid  in  1  one-cycle pulse, key_digit valid
- key_digit  in  4  BCD digit 0-9; values above 9 are ignored
- start  in  1  one-cycle pulse, start / resume / +30 s
- stop  in  1  one-cycle pulse, pause / clear
- door_open  in  1  level, door sensor
- first_s  out  4  seconds units BCD, 0-9
- second_s  out  4  seconds tens BCD, 0-5 once started
- first_m  out  4  minutes units BCD, 0-9
- second_m  out  4  minutes tens BCD, 0-9
- magnetron_on  out  1  high only in RUN
- state_o  out  3  current state encoding, for debug and the display

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low on rst_n.
  - Reset drives all digits to 0, magnetron_on to 0 and the state to IDLE.
  - rst_n asserted mid-RUN takes effect immediately, no completion is signalled.
- All outputs are registered; responses appear the cycle after the triggering input.
- States: IDLE, SET, RUN, PAUSE, DONE.
- IDLE:
  - key_valid with a digit 0-9 shifts the digit in and moves to SET.
  - start with door_open=0 loads 00:30 and moves to RUN (quick-start).
- SET:
  - Each valid key shifts the digits left by one position: first_s←digit, second_s←old first_s, first_m←old second_s, second_m←old first_m. The old second_m is discarded.
  - stop clears the digits and moves to IDLE.
  - start with door_open=0 first normalizes the time, then decides:
    - If second_s>5, add one minute and subtract 6 from second_s (example: 00:90 becomes 01:30).
    - If the minutes would exceed 99, saturate to 99:59.
    - If the normalized value is 00:00, move to IDLE.
    - Otherwise move to RUN. The digits, normalized, and the state change both appear the next cycle.
  - start with door_open=1 is ignored.
- RUN:
  - On sec_tick, decrement the time as BCD with borrow: seconds units 0→9 borrowing from seconds tens; seconds tens 0→5 borrowing from minutes units; minutes units 0→9 borrowing from minutes tens.
  - A decrement from 00:01 yields 00:00 and moves to DONE in the same update.
  - start adds 30 s as BCD (carry from seconds tens above 5 into the minutes), saturating at 99:59.
  - stop moves to PAUSE.
  - door_open=1 moves to PAUSE.
- PAUSE:
  - The digits hold.
  - start with door_open=0 moves back to RUN.
  - stop clears the digits and moves to IDLE.
  - Keys are ignored.
- DONE:
  - The digits hold at 00:00 so the downstream stage sees zero time.
  - stop, start or key_valid moves to IDLE; a key_valid here is consumed and not entered.
- Priority within a single cycle:
  - rst_n beats everything.
  - stop beats start.
  - door_open beats sec_tick (no decrement on that cycle).
  - A start and a sec_tick together in RUN apply only the +30 s.
  - key_valid is ignored in RUN, PAUSE and DONE.
- magnetron_on = (state==RUN), registered; it falls the cycle DONE or PAUSE is entered.
- sec_tick is ignored outside RUN.

Decomposition:
- Shared package microwave_pkg holds:
  - the state enum (IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4);
  - the BCD limit constants (SEC_T_MAX=5, DIGIT_MAX=9).
- One natural sub-module, bcd_time_alu (combinational), takes four digits plus an operation (dec1, add30, normalize) and returns four digits plus a zero flag.
- The top level holds the FSM and the digit registers.

Test Plan:
- Key 1,3,0 then start, door closed → digits 01:30, RUN, magnetron_on=1; 90 ticks → 00:00, DONE, magnetron_on=0 the cycle after the final tick.
- Key 9,0 then start → normalized to 01:30; key 9,9,9,9 then start → saturated to 99:59.
- In IDLE, start → 00:30 RUN; after 5 ticks (00:25) a start → 00:55; a start at 99:45 → 99:59.
- RUN at 02:00, door_open=1 in the same cycle as sec_tick → PAUSE, digits stay 02:00; door closed then start → RUN; next tick → 01:59.
- PAUSE, then start and stop in the same cycle → IDLE, all digits 0; key_digit=4'hA → ignored, state stays IDLE.
- rst_n low for 1 cycle mid-RUN at 00:42 → immediately IDLE, all digits 0, magnetron_on=0.
